// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: value/control inputs and scan outputs.
interface seven_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] i_value;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [NUM_DIGITS-1:0]   i_digit_en;
    logic                    i_blank_lz;
    logic                    i_hold;
    logic [NUM_DIGITS-1:0]   o_an;
    logic [6:0]              o_seg;
    logic                    o_dp;
    logic                    o_frame_start;

    // Source of display data (board logic / testbench).
    modport master (
        output i_value, i_dp, i_digit_en, i_blank_lz, i_hold,
        input  o_an, o_seg, o_dp, o_frame_start
    );

    // The scan driver itself.
    modport slave (
        input  i_value, i_dp, i_digit_en, i_blank_lz, i_hold,
        output o_an, o_seg, o_dp, o_frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment driver: prescaled digit scan, per-frame snapshot,
// ghosting guard, leading-zero blanking, digit enables and output polarity.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned BLANK_CYCLES   = 1,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
    input logic             clk,
    input logic             rstn,
    seven_seg_scan_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PS_W  = $clog2(CLK_DIV);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    // Reject illegal configurations at elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $fatal(1, "seven_seg_scan: NUM_DIGITS must be 1..16");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $fatal(1, "seven_seg_scan: CLK_DIV must be >= 2");
    end
    if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
        $fatal(1, "seven_seg_scan: BLANK_CYCLES must be < CLK_DIV");
    end

    logic [PS_W-1:0]       ps;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      val_snap;
    logic [NUM_DIGITS-1:0] dp_snap;
    logic [NUM_DIGITS-1:0] en_snap;
    logic                  blz_snap;

    logic                  frame_edge_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  zero_above;
    logic                  lit_c;
    logic [3:0]            nibble_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic [6:0]            seg_c;
    logic                  dp_c;

    // Active-high g..a hex decode.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign frame_edge_c = (ps == '0) && (idx == '0);

    // Prescaler, digit index and frame snapshot.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ps       <= '0;
            idx      <= '0;
            val_snap <= '0;
            dp_snap  <= '0;
            en_snap  <= '0;
            blz_snap <= 1'b0;
        end else begin
            if (ps == PS_W'(CLK_DIV - 1)) begin
                ps  <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                ps <= ps + PS_W'(1);
            end
            if (frame_edge_c && !bus.i_hold) begin
                val_snap <= bus.i_value;
                dp_snap  <= bus.i_dp;
                en_snap  <= bus.i_digit_en;
                blz_snap <= bus.i_blank_lz;
            end
        end
    end

    // Leading-zero mask: digit k blanked when it and everything above it is zero.
    always_comb begin
        zero_above = 1'b1;
        blank_c    = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_above = zero_above & (val_snap[4*k +: 4] == 4'h0);
            blank_c[k] = blz_snap & zero_above;
        end
    end

    // Next output values in active-high form, before polarity.
    always_comb begin
        nibble_c = val_snap[{idx, 2'b00} +: 4];
        lit_c    = (32'(ps) >= BLANK_CYCLES) && en_snap[idx] && !blank_c[idx];
        an_c     = '0;
        seg_c    = '0;
        dp_c     = 1'b0;
        if (lit_c) begin
            an_c  = NUM_DIGITS'(1) << idx;
            seg_c = hex_decode(nibble_c);
            dp_c  = dp_snap[idx];
        end
    end

    // Registered outputs with polarity applied last.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.o_an          <= {NUM_DIGITS{ACTIVE_LOW_AN}};
            bus.o_seg         <= {7{ACTIVE_LOW_SEG}};
            bus.o_dp          <= ACTIVE_LOW_SEG;
            bus.o_frame_start <= 1'b0;
        end else begin
            bus.o_an          <= an_c ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
            bus.o_seg         <= seg_c ^ {7{ACTIVE_LOW_SEG}};
            bus.o_dp          <= dp_c ^ ACTIVE_LOW_SEG;
            bus.o_frame_start <= frame_edge_c;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with a time-based reference model.
module tb_seven_seg_scan;
    localparam int unsigned N     = 8;
    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam int unsigned FRAME = N * DIV;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fs;
    } obs_t;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
        .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    obs_t expq [$];

    // Reference model: edges since reset release; frame data held in m_* arrays.
    int         cyc = 0;
    logic [3:0] m_nib [N];
    logic       m_dp  [N];
    logic       m_en  [N];
    logic       m_blz = 1'b0;

    always @(posedge clk) begin
        obs_t e;
        int   slot, pos, top;
        bit   lit;
        if (!rstn) begin
            cyc   = 0;
            m_blz = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                m_nib[k] = 4'h0; m_dp[k] = 1'b0; m_en[k] = 1'b0;
            end
            e = '{an: '1, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        end else begin
            slot = (cyc / int'(DIV)) % int'(N);
            pos  = cyc % int'(DIV);
            top  = 0;
            for (int k = 0; k < int'(N); k++) if (m_nib[k] != 4'h0) top = k;
            lit  = (pos >= int'(BLANK)) && m_en[slot] && !(m_blz && slot > top);
            e.an  = ~(lit ? (N'(1) << slot) : N'(0));
            e.seg = ~(lit ? seg_tbl[m_nib[slot]] : 7'h00);
            e.dp  = ~(lit && m_dp[slot]);
            e.fs  = (pos == 0) && (slot == 0);
            if (pos == 0 && slot == 0 && !bus.i_hold) begin
                for (int k = 0; k < int'(N); k++) begin
                    m_nib[k] = bus.i_value[4*k +: 4];
                    m_dp[k]  = bus.i_dp[k];
                    m_en[k]  = bus.i_digit_en[k];
                end
                m_blz = bus.i_blank_lz;
            end
            cyc++;
        end
        expq.push_back(e);
    end

    // Monitor: compare the registered outputs half a cycle after each edge.
    always @(negedge clk) begin
        obs_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{an: bus.o_an, seg: bus.o_seg, dp: bus.o_dp, fs: bus.o_frame_start};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scan_out t=%0t: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         $time, a.an, a.seg, a.dp, a.fs, e.an, e.seg, e.dp, e.fs);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic [4*N-1:0] v, input logic [N-1:0] dp,
                          input logic [N-1:0] en, input logic blz, input logic hold);
        bus.i_value    = v;
        bus.i_dp       = dp;
        bus.i_digit_en = en;
        bus.i_blank_lz = blz;
        bus.i_hold     = hold;
    endtask

    initial begin
        int waited;
        rstn = 1'b0;
        set_in(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, 1'b0);
        cycles(3);
        rstn = 1'b1;
        cycles(2 * FRAME);

        // Leading-zero blanking, changed mid-frame.
        cycles(5);
        set_in(32'h00000120, 8'h00, 8'hFF, 1'b1, 1'b0);
        cycles(3 * FRAME);

        // All-zero value with and without blanking.
        set_in(32'h0, 8'h00, 8'hFF, 1'b1, 1'b0);
        cycles(2 * FRAME);
        set_in(32'h0, 8'h00, 8'hFF, 1'b0, 1'b0);
        cycles(2 * FRAME);

        // Digit enable mask and decimal point.
        set_in(32'h89ABCDEF, 8'h01, 8'h0F, 1'b0, 1'b0);
        cycles(2 * FRAME);

        // Hold across frames, then release.
        set_in(32'h89ABCDEF, 8'h01, 8'h0F, 1'b0, 1'b1);
        cycles(3);
        set_in(32'h13572468, 8'hA5, 8'hFF, 1'b0, 1'b1);
        cycles(3 * FRAME);
        bus.i_hold = 1'b0;
        cycles(2 * FRAME);

        // Randomised inputs and hold toggling.
        for (int i = 0; i < 30; i++) begin
            set_in($urandom, 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) bus.i_value[31:16] = '0;
            cycles($urandom_range(1, 40));
        end
        bus.i_hold = 1'b0;
        set_in(32'h00C0FFEE, 8'h10, 8'hFF, 1'b1, 1'b0);
        cycles(2 * FRAME);

        // Reset during the digit 5 slot.
        waited = 0;
        while (bus.o_an !== 8'hDF && waited < 4 * int'(FRAME)) begin
            cycles(1);
            waited++;
        end
        total++;
        if (bus.o_an !== 8'hDF) begin
            bad++;
            $display("FAIL wait_digit5: got an=%h, want DF within %0d cycles", bus.o_an, 4 * FRAME);
        end
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(2 * FRAME);

        total++;
        if (expq.size() > 1) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want <=1", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised multiplexed seven-segment display driver for board top-levels: time-multiplexes NUM_DIGITS hex nibbles onto a shared segment bus with one anode per digit.
- Supersedes the fixed 8-digit, clock-rate scan with a prescaled refresh rate, per-frame value snapshot (no tearing), an inter-digit ghosting guard, leading-zero blanking, a digit-enable mask, decimal points and selectable output polarity.
- Sits in the board wrapper on the core clock and displays debug counters or GPIO-driven values.

Parameters:
NUM_DIGITS, 8, number of digits/anodes; legal 1..16
CLK_DIV, 100000, clk cycles per digit slot; legal >= 2
BLANK_CYCLES, 1, cycles at the start of each slot with all anodes off; legal 0..CLK_DIV-1
ACTIVE_LOW_SEG, 1, 1 = o_seg/o_dp are driven low to light
ACTIVE_LOW_AN, 1, 1 = o_an is driven low to select a digit

Ports:
clk  input  1  clock; all logic is on the rising edge
rstn  input  1  reset, synchronous, active-low
i_value  input  4*NUM_DIGITS  hex nibbles; digit k = i_value[4k+3:4k], digit 0 is rightmost
i_dp  input  NUM_DIGITS  decimal-point request per digit
i_digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode inactive
i_blank_lz  input  1  leading-zero blanking enable
i_hold  input  1  1 = skip snapshot updates and keep displaying the last captured frame
o_an  output  NUM_DIGITS  anode selects, registered
o_seg  output  7  segments, registered; bit0=a ... bit6=g
o_dp  output  1  decimal point, registered
o_frame_start  output  1  one-cycle pulse marking a snapshot opportunity, registered

Behaviour:
- Reset (rstn=0 at a clk edge): prescaler=0, idx=0, snapshot registers=0, o_an all inactive, o_seg and o_dp inactive (unlit), o_frame_start=0. Reset asserted mid-scan takes effect on the next edge, with no partial-frame completion.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. At the terminal count (tick), idx advances; idx wraps from NUM_DIGITS-1 to 0. idx width is max(1, clog2(NUM_DIGITS)).
- Snapshot: on an edge where prescaler==0, idx==0 and i_hold==0, capture i_value, i_dp, i_digit_en and i_blank_lz.
  - The first such edge is the first edge after reset release.
  - With i_hold=1 the snapshot is retained; capture resumes at the next frame boundary after i_hold falls.
  - Input changes mid-frame never reach the display before the next boundary.
- o_frame_start is 1 in the cycle after every edge with prescaler==0 and idx==0, regardless of i_hold.
- Output registers are updated every cycle from the current (prescaler, idx, snapshot), giving 1-cycle latency.
  - Anode: the digit idx is active only when prescaler >= BLANK_CYCLES, en_snap[idx]=1 and the digit is not leading-zero blanked. All other anodes are inactive.
- Leading-zero blanking: digit k (k>=1) is blanked when blz_snap=1 and nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Blanked or disabled digits: o_seg and o_dp are inactive during that slot.
- Decode is active-high g..a, in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- o_dp = dp_snap[idx] when the digit is lit.
- Polarity is applied last:
  - ACTIVE_LOW_SEG inverts o_seg and o_dp.
  - ACTIVE_LOW_AN inverts o_an.
  - The reset and inactive values follow the selected polarity.
- Frame period is NUM_DIGITS*CLK_DIV cycles, and each digit is lit for CLK_DIV-BLANK_CYCLES cycles.
- Out-of-range parameters are a fatal elaboration error.

Test Plan:
- NUM_DIGITS=8, CLK_DIV=4, BLANK_CYCLES=1, active-low, i_value=32'h89ABCDEF, en=FF -> o_an goes FE,FD,...,7F, each low for 3 of 4 cycles, with 1 cycle of FF between slots. Digit 0 drives o_seg=7'h0E (~71) and digit 7 drives 7'h00 (~7F). o_frame_start pulses every 32 cycles.
- i_value=32'h00000120, i_blank_lz=1 -> digits 3..7 are never selected. Digits 0,1,2 show 0,2,1 (o_seg 40,24,79 active-low).
- i_value=0, i_blank_lz=1 -> only digit 0 is selected and shows 7'h40. With i_blank_lz=0, all 8 digits show 7'h40.
- i_value changed mid-frame -> the display is unchanged until the next o_frame_start. With i_hold=1 across two frames, the old value persists; after i_hold falls, the new value appears from the next boundary.
- i_digit_en=8'h0F, i_dp=8'h01 -> anodes 4..7 stay high, and o_dp=0 only during the digit 0 slot.
- rstn driven low during the digit 5 slot -> on the next edge o_an=FF and o_seg=7F. After release, the scan restarts at digit 0 and the snapshot is recaptured on the first edge.
